// File: rtl/lif_pkg.sv
// Shared types and helpers for the time-multiplexed LIF neuron scheduler.
package lif_pkg;

    localparam int LIF_STATE_W = 8;
    localparam int LIF_IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [LIF_STATE_W-1:0] sat_add(input logic [LIF_STATE_W-1:0] a,
                                                       input logic [LIF_STATE_W-1:0] b);
        logic [LIF_STATE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[LIF_STATE_W] ? {LIF_STATE_W{1'b1}} : s[LIF_STATE_W-1:0];
    endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational leak/integrate/threshold/refractory update for one neuron.
module lif_update_core
    import lif_pkg::*;
#(
    parameter int STATE_W      = LIF_STATE_W,
    parameter int THRESHOLD    = 128,
    parameter int DECAY_SHIFT  = 1,
    parameter int REFRAC_STEPS = 2,
    parameter int REFRAC_W     = 2
) (
    input  logic [STATE_W-1:0]  v_i,
    input  logic [STATE_W-1:0]  pend_i,
    input  logic [REFRAC_W-1:0] refrac_i,
    output logic [STATE_W-1:0]  v_next_o,
    output logic [REFRAC_W-1:0] refrac_next_o,
    output logic                fire_o
);

    localparam logic [STATE_W:0]  THR         = THRESHOLD[STATE_W:0];
    localparam logic [REFRAC_W-1:0] REFRAC_INIT = REFRAC_STEPS[REFRAC_W-1:0];

    logic [STATE_W:0] v_ext;
    logic [STATE_W:0] sum_raw;
    logic [STATE_W:0] sum_sat;

    always_comb begin
        v_ext   = {1'b0, v_i};
        sum_raw = v_ext - (v_ext >> DECAY_SHIFT) + {1'b0, pend_i};
        sum_sat = sum_raw[STATE_W] ? {1'b0, {STATE_W{1'b1}}} : sum_raw;

        v_next_o      = '0;
        refrac_next_o = '0;
        fire_o        = 1'b0;
        // A refractory neuron is held at rest and its input is dropped.
        if (refrac_i != '0) begin
            refrac_next_o = refrac_i - REFRAC_W'(1);
        end else if (sum_sat >= THR) begin
            fire_o        = 1'b1;
            refrac_next_o = REFRAC_INIT;
        end else begin
            v_next_o = sum_sat[STATE_W-1:0];
        end
    end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Scans N_NEURONS virtual LIF neurons one per cycle per step strobe, emitting
// spikes in index order through a valid/ready port with stall on backpressure.
module lif_neuron_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS    = 4,
    parameter int IDX_W        = $clog2(N_NEURONS),
    parameter int STATE_W      = LIF_STATE_W,
    parameter int THRESHOLD    = 128,
    parameter int DECAY_SHIFT  = 1,
    parameter int REFRAC_STEPS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cur_valid_i,
    input  logic [IDX_W-1:0]   cur_idx_i,
    input  logic [STATE_W-1:0] cur_i,
    input  logic               step_i,
    output logic               spike_valid_o,
    output logic [IDX_W-1:0]   spike_idx_o,
    input  logic               spike_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               overrun_o,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic [STATE_W-1:0] rd_state_o
);

    localparam int REFRAC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_e state_q, state_d;
    logic [IDX_W-1:0]    k_q, k_d;
    logic [STATE_W-1:0]  v_q      [N_NEURONS];
    logic [STATE_W-1:0]  pend_q   [N_NEURONS];
    logic [REFRAC_W-1:0] refrac_q [N_NEURONS];
    logic                spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0]    spike_idx_q, spike_idx_d;
    logic                overrun_q, overrun_d;
    logic [STATE_W-1:0]  rd_q;

    logic [STATE_W-1:0]  core_v_next;
    logic [REFRAC_W-1:0] core_refrac_next;
    logic                core_fire;
    logic                commit;

    lif_update_core #(
        .STATE_W      (STATE_W),
        .THRESHOLD    (THRESHOLD),
        .DECAY_SHIFT  (DECAY_SHIFT),
        .REFRAC_STEPS (REFRAC_STEPS),
        .REFRAC_W     (REFRAC_W)
    ) u_core (
        .v_i           (v_q[k_q]),
        .pend_i        (pend_q[k_q]),
        .refrac_i      (refrac_q[k_q]),
        .v_next_o      (core_v_next),
        .refrac_next_o (core_refrac_next),
        .fire_o        (core_fire)
    );

    // Valid/ready: an event transfers on a cycle where spike_valid_o and
    // spike_ready_i are both high; valid and index stay stable until then.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        commit        = 1'b0;
        spike_valid_d = spike_valid_q && !spike_ready_i;
        spike_idx_d   = spike_idx_q;
        overrun_d     = step_i && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (step_i) begin
                    state_d = SCAN;
                    k_d     = '0;
                end
            end
            SCAN: begin
                // A firing neuron may only commit when the output slot frees up.
                commit = !core_fire || !spike_valid_q || spike_ready_i;
                if (commit) begin
                    if (core_fire) begin
                        spike_valid_d = 1'b1;
                        spike_idx_d   = k_q;
                    end
                    if (k_q == LAST_IDX) state_d = DONE;
                    else                 k_d     = k_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            overrun_q     <= 1'b0;
            rd_q          <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            overrun_q     <= overrun_d;
            rd_q          <= v_q[rd_idx_i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i]      <= '0;
                pend_q[i]   <= '0;
                refrac_q[i] <= '0;
            end
        end else begin
            if (commit) begin
                v_q[k_q]      <= core_v_next;
                refrac_q[k_q] <= core_refrac_next;
                pend_q[k_q]   <= '0;
            end
            // Injection landing on the neuron being committed seeds the next step.
            if (cur_valid_i) begin
                if (commit && (cur_idx_i == k_q)) pend_q[cur_idx_i] <= cur_i;
                else pend_q[cur_idx_i] <= sat_add(pend_q[cur_idx_i], cur_i);
            end
        end
    end

    assign spike_valid_o = spike_valid_q;
    assign spike_idx_o   = spike_idx_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign overrun_o     = overrun_q;
    assign rd_state_o    = rd_q;

endmodule
